// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : uart_pkg                                                |
// | Desc   : Constants and types shared by the UART transmitter and  |
// |          receiver: default bit period, 8N1 frame constants and   |
// |          the transmitter FSM state type.                         |
// | Ports  : none (package)                                          |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
package uart_pkg;

  // 50 MHz / 115200 baud, rounded down
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : sync_fifo                                               |
// | Desc   : Single-clock FIFO with registered occupancy counter.    |
// |          Head entry is presented on dout whenever non-empty.     |
// | Ports  : clk_50, rst (sync, active-high), push/din write side,   |
// |          pop/dout read side, full, empty, count (occupancy).     |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4   // power of two, at least 2
) (
  input  logic                     clk_50,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_CNT_W  = c_ADDR_W + 1;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;

  logic w_do_push;
  logic w_do_pop;

  // Guard against overflow/underflow so the counter never wraps
  assign w_do_push = push && !full;
  assign w_do_pop  = pop  && !empty;

  // Storage carries no reset; only pointers and occupancy define validity
  always_ff @(posedge clk_50) begin
    if (w_do_push && !rst) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == c_CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : uart_tx                                                 |
// | Desc   : Queued 8N1 UART transmitter, LSB first, line idles high.|
// |          Bytes enter a FIFO via valid/ready and are serialised   |
// |          back-to-back with no idle gap while the queue has data. |
// | Ports  : clk_50, rst (sync, active-high), tx_data/tx_valid/      |
// |          tx_ready byte input handshake, tx_out serial line,      |
// |          busy (frame in progress or queue non-empty).            |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       busy
);

  localparam int c_TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]           c_LAST_BIT   = 3'(DATA_BITS - 1);

  tx_state_t           r_state,   w_state_nxt;
  logic [c_TIMER_W-1:0] r_timer,  w_timer_nxt;
  logic [2:0]          r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]          r_shift,   w_shift_nxt;
  logic                r_tx_out,  w_tx_out_nxt;

  logic               w_push;
  logic               w_pop;
  logic [7:0]         w_fifo_dout;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [c_CNT_W-1:0] w_fifo_count;
  logic               w_bit_end;

  // Ready depends only on registered occupancy: a pop on this edge
  // does not free a slot until the next cycle.
  assign tx_ready = !w_fifo_full && !rst;
  assign w_push   = tx_valid && tx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_50 (clk_50),
    .rst    (rst),
    .push   (w_push),
    .pop    (w_pop),
    .din    (tx_data),
    .dout   (w_fifo_dout),
    .full   (w_fifo_full),
    .empty  (w_fifo_empty),
    .count  (w_fifo_count)
  );

  assign w_bit_end = (r_timer == c_TIMER_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_tx_out_nxt  = r_tx_out;
    w_pop         = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_fifo_dout;
          w_bit_cnt_nxt = '0;
          w_timer_nxt   = '0;
          w_tx_out_nxt  = START_BIT;
          w_state_nxt   = ST_START;
        end
      end

      ST_START: begin
        if (w_bit_end) begin
          w_timer_nxt  = '0;
          w_tx_out_nxt = r_shift[0];
          w_state_nxt  = ST_DATA;
        end else begin
          w_timer_nxt = r_timer + c_TIMER_W'(1);
        end
      end

      ST_DATA: begin
        if (w_bit_end) begin
          w_timer_nxt = '0;
          if (r_bit_cnt == c_LAST_BIT) begin
            w_tx_out_nxt = STOP_BIT;
            w_state_nxt  = ST_STOP;
          end else begin
            // r_shift[0] is on the line; bit 1 becomes the next output
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            w_shift_nxt   = r_shift >> 1;
            w_tx_out_nxt  = r_shift[1];
          end
        end else begin
          w_timer_nxt = r_timer + c_TIMER_W'(1);
        end
      end

      ST_STOP: begin
        if (w_bit_end) begin
          w_timer_nxt = '0;
          if (!w_fifo_empty) begin
            // Chain straight into the next start bit, no idle gap
            w_pop         = 1'b1;
            w_shift_nxt   = w_fifo_dout;
            w_bit_cnt_nxt = '0;
            w_tx_out_nxt  = START_BIT;
            w_state_nxt   = ST_START;
          end else begin
            w_tx_out_nxt = STOP_BIT;
            w_state_nxt  = ST_IDLE;
          end
        end else begin
          w_timer_nxt = r_timer + c_TIMER_W'(1);
        end
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_tx_out_nxt = STOP_BIT;
      end
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_tx_out  <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_tx_out  <= w_tx_out_nxt;
    end
  end

  assign tx_out = r_tx_out;
  assign busy   = (r_state != ST_IDLE) || (w_fifo_count != '0);

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_uart_tx                                              |
// | Desc   : Self-checking bench for uart_tx. A loopback receiver    |
// |          decodes frames from tx_out and compares them against a  |
// |          queue of bytes accepted by the handshake. A second DUT  |
// |          at the default bit period checks real-rate timing.      |
// | Ports  : none                                                    |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module tb_uart_tx;

  localparam int CPB      = 4;
  localparam int DEPTH    = 4;
  localparam int SLOW_CPB = 434;
  localparam int FRAME    = 10 * CPB;

  logic       clk_50 = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_out;
  logic       busy;

  logic [7:0] s_tx_data;
  logic       s_tx_valid;
  logic       s_tx_ready;
  logic       s_tx_out;
  logic       s_busy;

  always #5 clk_50 = ~clk_50;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) u_dut (
    .clk_50   (clk_50),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_out   (tx_out),
    .busy     (busy)
  );

  uart_tx u_dut_slow (
    .clk_50   (clk_50),
    .rst      (rst),
    .tx_data  (s_tx_data),
    .tx_valid (s_tx_valid),
    .tx_ready (s_tx_ready),
    .tx_out   (s_tx_out),
    .busy     (s_busy)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  int         start_times[$];
  int         cyc = 0;

  always @(posedge clk_50) cyc++;

  // ---------------- loopback receiver / scoreboard ----------------
  logic       mon_active = 1'b0;
  int         mon_cnt    = 0;
  logic [7:0] mon_byte   = '0;
  logic [7:0] mon_exp;

  always @(negedge clk_50) begin
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx_out === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_byte   = '0;
        start_times.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      for (int i = 0; i < 8; i++) begin
        if (mon_cnt == CPB * (i + 1) + CPB / 2) mon_byte[i] = tx_out;
      end
      if (mon_cnt == CPB * 9 + CPB / 2) begin
        n_tests++;
        if (tx_out !== 1'b1) begin
          n_fail++;
          $display("FAIL rx_stop_bit: got %b expected 1", tx_out);
        end
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rx_unexpected_frame: got %02h expected no frame", mon_byte);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_byte !== mon_exp) begin
            n_fail++;
            $display("FAIL rx_byte: got %02h expected %02h", mon_byte, mon_exp);
          end
        end
        mon_active = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk_50);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((busy !== 1'b0 || mon_active) && n < limit) begin
      tick();
      n++;
    end
    n_tests++;
    if (n >= limit) begin
      n_fail++;
      $display("FAIL wait_idle_timeout: got busy=%b after %0d cycles expected 0", busy, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst        = 1'b1;
    tx_valid   = 1'b1;   // offered during reset, must be ignored
    tx_data    = 8'hAA;
    s_tx_valid = 1'b0;
    s_tx_data  = 8'h00;
    repeat (3) tick();
    n_tests++;
    if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", tx_ready); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++;
    if (tx_out !== 1'b1) begin n_fail++; $display("FAIL reset_tx_out: got %b expected 1", tx_out); end
    n_tests++;
    if (s_tx_out !== 1'b1) begin n_fail++; $display("FAIL reset_slow_tx_out: got %b expected 1", s_tx_out); end
    rst      = 1'b0;
    tx_valid = 1'b0;
    #1;
    n_tests++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b expected 1", tx_ready); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    tick();
    n_tests++;
    if (busy !== 1'b0 || tx_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_valid_ignored: got busy=%b tx_out=%b expected busy=0 tx_out=1", busy, tx_out);
    end
  endtask

  task automatic test_single_byte();
    logic [9:0] fr;
    fr = {1'b1, 8'h77, 1'b0};
    tx_data  = 8'h77;
    tx_valid = 1'b1;
    n_tests++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", tx_ready); end
    exp_q.push_back(8'h77);
    tick();                      // push edge N
    tx_valid = 1'b0;
    n_tests++;
    if (tx_out !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_after_push: got tx_out=%b busy=%b expected 1 1", tx_out, busy);
    end
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        tick();
        n_tests++;
        if (tx_out !== fr[b]) begin
          n_fail++;
          $display("FAIL single_wave bit%0d cyc%0d: got %b expected %b", b, c, tx_out, fr[b]);
        end
      end
    end
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_end: got %b expected 1", busy); end
    tick();
    n_tests++;
    if (busy !== 1'b0 || tx_out !== 1'b1) begin
      n_fail++;
      $display("FAIL single_idle: got busy=%b tx_out=%b expected 0 1", busy, tx_out);
    end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_scoreboard: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int s0;
    bytes = '{8'h61, 8'h73, 8'h64};
    wait_idle(200);
    s0 = start_times.size();
    for (int i = 0; i < 3; i++) begin
      tx_data  = bytes[i];
      tx_valid = 1'b1;
      n_tests++;
      if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b expected 1", i, tx_ready); end
      if (tx_ready === 1'b1) exp_q.push_back(bytes[i]);
      tick();
    end
    tx_valid = 1'b0;
    wait_idle(300);
    n_tests++;
    if (start_times.size() != s0 + 3) begin
      n_fail++;
      $display("FAIL b2b_frames: got %0d expected 3", start_times.size() - s0);
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_tests++;
        if (start_times[s0+i] - start_times[s0+i-1] != FRAME) begin
          n_fail++;
          $display("FAIL b2b_gap%0d: got %0d expected %0d", i,
                   start_times[s0+i] - start_times[s0+i-1], FRAME);
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_scoreboard: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int s0;
    logic exp_rdy;
    wait_idle(200);
    s0 = start_times.size();
    for (int k = 0; k < 6; k++) begin
      exp_rdy  = (k < 5);  // 1 in the shifter plus 4 queued
      tx_data  = 8'hC0 + 8'(k);
      tx_valid = 1'b1;
      n_tests++;
      if (tx_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_ready%0d: got %b expected %b", k, tx_ready, exp_rdy); end
      if (tx_ready === 1'b1) exp_q.push_back(tx_data);
      tick();
    end
    tx_valid = 1'b0;
    wait_idle(400);
    n_tests++;
    if (start_times.size() != s0 + 5) begin
      n_fail++;
      $display("FAIL bp_frames: got %0d expected 5", start_times.size() - s0);
    end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_scoreboard: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_full_pop_same_edge();
    int s0;
    logic exp_rdy;
    wait_idle(200);
    s0 = start_times.size();
    // Offer k lands on edge Ek. Queue fills at E5; the first frame ends
    // with a pop at E42, which must refuse that edge's push and accept at E43.
    for (int k = 1; k <= 44; k++) begin
      exp_rdy  = (k <= 5) || (k == 43);
      tx_data  = (k <= 5) ? 8'hA0 + 8'(k) : ((k <= 43) ? 8'hE5 : 8'hF0);
      tx_valid = 1'b1;
      n_tests++;
      if (tx_ready !== exp_rdy) begin n_fail++; $display("FAIL fullpop_ready%0d: got %b expected %b", k, tx_ready, exp_rdy); end
      if (tx_ready === 1'b1) exp_q.push_back(tx_data);
      tick();
    end
    tx_valid = 1'b0;
    wait_idle(500);
    n_tests++;
    if (start_times.size() != s0 + 6) begin
      n_fail++;
      $display("FAIL fullpop_frames: got %0d expected 6", start_times.size() - s0);
    end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL fullpop_scoreboard: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_midframe();
    int s0;
    int bad;
    wait_idle(200);
    for (int k = 0; k < 3; k++) begin
      tx_data  = 8'h10 + 8'(k);
      tx_valid = 1'b1;
      exp_q.push_back(tx_data);
      tick();
    end
    tx_valid = 1'b0;
    // Frame started at E2; now after E3. Sixteen more edges put us in data bit 3.
    repeat (16) tick();
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy: got %b expected 1", busy); end
    rst = 1'b1;
    tick();
    n_tests++;
    if (tx_out !== 1'b1) begin n_fail++; $display("FAIL midrst_tx_out: got %b expected 1", tx_out); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_tests++;
    if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", tx_ready); end
    rst = 1'b0;
    exp_q.delete();
    s0  = start_times.size();
    bad = 0;
    repeat (60) begin
      tick();
      if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", bad); end
    n_tests++;
    if (start_times.size() != s0) begin
      n_fail++;
      $display("FAIL midrst_no_start: got %0d frames expected 0", start_times.size() - s0);
    end
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    exp_q.push_back(8'h3C);
    tick();
    tx_valid = 1'b0;
    wait_idle(200);
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_recover: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_default_rate();
    logic [9:0] fr;
    int bad;
    fr = {1'b1, 8'h64, 1'b0};
    s_tx_data  = 8'h64;
    s_tx_valid = 1'b1;
    n_tests++;
    if (s_tx_ready !== 1'b1) begin n_fail++; $display("FAIL slow_ready: got %b expected 1", s_tx_ready); end
    tick();
    s_tx_valid = 1'b0;
    n_tests++;
    if (s_tx_out !== 1'b1) begin n_fail++; $display("FAIL slow_after_push: got %b expected 1", s_tx_out); end
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < SLOW_CPB; c++) begin
        tick();
        if (s_tx_out !== fr[b]) bad++;
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL slow_bit%0d: got %0d wrong cycles expected 0 (level %b)", b, bad, fr[b]);
      end
    end
    n_tests++;
    if (s_busy !== 1'b1) begin n_fail++; $display("FAIL slow_busy_end: got %b expected 1", s_busy); end
    tick();
    n_tests++;
    if (s_busy !== 1'b0 || s_tx_out !== 1'b1) begin
      n_fail++;
      $display("FAIL slow_idle: got busy=%b tx_out=%b expected 0 1", s_busy, s_tx_out);
    end
  endtask

  initial begin
    rst        = 1'b1;
    tx_valid   = 1'b0;
    tx_data    = '0;
    s_tx_valid = 1'b0;
    s_tx_data  = '0;
    tick();
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_backpressure();
    test_full_pop_same_edge();
    test_reset_midframe();
    test_default_rate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule : tb_uart_tx
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk_50 cycles per serial bit (50 MHz / 115200 baud).
REQ-002 Parameter FIFO_DEPTH, default 4, number of byte entries in the transmit queue; power of two, at least 2.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk_50  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 tx_data  input  8  byte to transmit; sampled when tx_valid and tx_ready are both high.
REQ-007 tx_valid  input  1  producer offers tx_data this cycle.
REQ-008 tx_ready  output  1  queue can accept a byte this cycle.
REQ-009 tx_out  output  1  serial line, 8N1 framing, LSB first; idles high; drives a receiver's rx_in.
REQ-010 busy  output  1  high while a frame is in progress or the queue is non-empty.

Function
REQ-011 A byte is accepted only on an edge where tx_valid=1 and tx_ready=1; in all other cases tx_data is ignored.
REQ-012 tx_ready = (queue occupancy < FIFO_DEPTH) and not rst; it is derived from the registered occupancy only, so a same-cycle pop never makes room for a push.
REQ-013 A push and a pop on the same edge leave the occupancy unchanged. Queue order is strictly FIFO.
REQ-014 The FSM has four states: IDLE, START, DATA, STOP. The encoding is in the package.
REQ-015 IDLE with queue non-empty: on the next edge, pop the head into the shift register, set bit_cnt=0, timer=0, tx_out<=0, and enter START.
REQ-016 Each bit is held on tx_out for exactly CLKS_PER_BIT cycles. The timer counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances.
REQ-017 START advances to DATA with tx_out<=bit0. DATA shifts out bits 0..7 and, after bit 7, enters STOP with tx_out<=1.
REQ-018 At the end of STOP: if the queue is non-empty, pop and enter START directly with no idle gap; otherwise enter IDLE with tx_out=1.
REQ-019 Latency: a byte pushed at edge N into an idle, empty block drives tx_out low after edge N+1. A frame lasts 10*CLKS_PER_BIT cycles.
REQ-020 tx_out is a register output with no combinational path from any input.
REQ-021 busy = (state != IDLE) or (occupancy != 0), registered-state based.
REQ-022 The timer width is clog2(CLKS_PER_BIT). bit_cnt is 3 bits. The occupancy counter is clog2(FIFO_DEPTH)+1 bits and never wraps.

Reset
REQ-023 While rst=1 at an edge: state<=IDLE, tx_out<=1, timer<=0, bit_cnt<=0, and the queue is flushed (occupancy 0, pointers 0).
REQ-024 During reset, tx_ready=0 and busy=0. On the first cycle after rst deasserts, tx_ready=1 and busy=0.
REQ-025 Reset mid-frame aborts the frame: tx_out is 1 after the reset edge, no partial byte resumes, and queued bytes are discarded.
REQ-026 A tx_valid asserted during reset is not accepted.

Structure
REQ-027 Shared package uart_pkg holds the CLKS_PER_BIT default, the FSM state typedef, and the frame constants START_BIT=0, STOP_BIT=1, DATA_BITS=8, shared with the receiver.
REQ-028 The queue is the sub-module sync_fifo (parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty, count, rst synchronous). The FSM, timer and shifter stay in uart_tx.
REQ-029 Target size is 120-400 RTL lines in total.

Verification (bench with CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted)
REQ-030 Push 0x77 ('w') once from reset-idle -> tx_out low one cycle after the push edge, then bits 1,1,1,0,1,1,1,0 for 4 cycles each, then high for 4 cycles; busy falls after 40 cycles.
REQ-031 Push 0x61, 0x73, 0x64 back-to-back -> three contiguous 40-cycle frames with no high gap between a stop bit and the next start bit; a loopback rc-style receiver decodes a, s, d in order.
REQ-032 Hold tx_valid high for 6 cycles with distinct bytes while idle -> tx_ready drops after the queue holds 4 bytes plus the 1 popped into the shifter; exactly the accepted bytes are transmitted, in order.
REQ-033 Assert rst during bit 3 of a frame with 2 bytes queued -> tx_out=1 the next cycle, busy=0, and no further start bit until a new push.
REQ-034 Default CLKS_PER_BIT=434 with one byte 0x64 -> each bit is exactly 434 cycles wide; the frame totals 4340 cycles.
REQ-035 tx_valid=1 when the queue is full and a pop occurs on the same edge -> the push is refused; occupancy goes 4 -> 3, and the byte is accepted on the following edge.
